// File: rtl/wrr_port_arbiter_pkg.sv
// Shared definitions for the weighted round-robin packet merge.
package wrr_port_arbiter_pkg;

  // Arbiter FSM encoding
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  // Ceiling log2, used to size port indices (result is at least 1 for v >= 2)
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Bit offset of slice idx inside a grouped bus of width-bit slices
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_next_port.sv
// Combinational circular priority encoder: first set bit of eligible_i at or
// after start_i, wrapping past the top port back to port 0.
module rr_next_port
  import wrr_port_arbiter_pkg::*;
#(
  parameter int NumPorts = 5,
  parameter int IdxWidth = clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] eligible_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic                found_o,
  output logic [IdxWidth-1:0] idx_o
);

  // Scan from the far end backwards so the closest candidate to start_i wins
  always_comb begin
    int cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      cand = (int'(start_i) + k) % NumPorts;
      if (eligible_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/wrr_port_arbiter.sv
// Packet-granular weighted round-robin merge of N AXI4-Stream ports onto one.
// Each port gets up to weight[i] whole packets per turn; weight 0 masks it.
module wrr_port_arbiter
  import wrr_port_arbiter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_NUM_INPUT_IF     = 5,
  parameter int C_WEIGHT_WIDTH       = 4,
  localparam int GrantWidth          = clog2(C_S_NUM_INPUT_IF)
) (
  input  logic                                               axi_aclk,
  input  logic                                               axi_reset,
  input  logic                                               sw_rst,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata_grp,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb_grp,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser_grp,
  input  logic [C_S_NUM_INPUT_IF-1:0]                         s_axis_tvalid_grp,
  input  logic [C_S_NUM_INPUT_IF-1:0]                         s_axis_tlast_grp,
  output logic [C_S_NUM_INPUT_IF-1:0]                         s_axis_tready_grp,
  input  logic [C_S_NUM_INPUT_IF*C_WEIGHT_WIDTH-1:0]          weight_grp,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                     m_axis_tuser,
  output logic                                               m_axis_tvalid,
  output logic                                               m_axis_tlast,
  input  logic                                               m_axis_tready,
  output logic [GrantWidth-1:0]                               grant_port,
  output logic                                               grant_active
);

  localparam int N  = C_S_NUM_INPUT_IF;
  localparam int W  = C_WEIGHT_WIDTH;
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  localparam logic [GrantWidth-1:0] GrantLast = GrantWidth'(N - 1);
  localparam logic [GrantWidth-1:0] GrantOne  = GrantWidth'(1);
  localparam logic [W-1:0]          CreditOne = W'(1);

  logic                  rst;
  logic [0:0]            state_q, state_d;
  logic [GrantWidth-1:0] grant_q, grant_d;
  logic [W-1:0]          credit_q, credit_d;

  logic [N-1:0]          eligible;
  logic [GrantWidth-1:0] search_start;
  logic                  search_found;
  logic [GrantWidth-1:0] search_idx;
  logic                  send;

  assign rst  = axi_reset | sw_rst;
  assign send = (state_q == StSend);

  // A port may be picked only when it offers data and is not masked off
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = s_axis_tvalid_grp[i] && (weight_grp[i*W +: W] != '0);
    end
    // Current holder is examined last by starting one past it
    search_start = (grant_q == GrantLast) ? '0 : grant_q + GrantOne;
  end

  rr_next_port #(
    .NumPorts (N),
    .IdxWidth (GrantWidth)
  ) u_rr_next_port (
    .eligible_i (eligible),
    .start_i    (search_start),
    .found_o    (search_found),
    .idx_o      (search_idx)
  );

  // Next-state: keep the turn while credit remains, else pick the next port
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    case (state_q)
      StIdle: begin
        if ((credit_q != '0) && eligible[grant_q]) begin
          state_d = StSend;
        end else if (search_found) begin
          grant_d  = search_idx;
          // Weight is only sampled here, so mid-turn edits wait for the next pick
          credit_d = weight_grp[slice_lsb(int'(search_idx), W) +: W];
          state_d  = StSend;
        end
      end
      StSend: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          credit_d = (credit_q == '0) ? '0 : credit_q - CreditOne;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output passthrough from the granted port; everything gated off outside SEND
  always_comb begin
    m_axis_tdata      = s_axis_tdata_grp[slice_lsb(int'(grant_q), DW) +: C_M_AXIS_DATA_WIDTH];
    m_axis_tstrb      = s_axis_tstrb_grp[slice_lsb(int'(grant_q), DW / 8) +:
                                         C_M_AXIS_DATA_WIDTH / 8];
    m_axis_tuser      = s_axis_tuser_grp[slice_lsb(int'(grant_q), UW) +: C_M_AXIS_TUSER_WIDTH];
    m_axis_tvalid     = send && s_axis_tvalid_grp[grant_q];
    m_axis_tlast      = send && s_axis_tlast_grp[grant_q];
    s_axis_tready_grp = '0;
    if (send) begin
      s_axis_tready_grp[grant_q] = m_axis_tready;
    end
    grant_port   = grant_q;
    grant_active = send;
  end

  // State registers; grant resets to the last port so the first search starts at 0
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= GrantLast;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_wrr_port_arbiter.sv
// Scoreboard bench: backlogged sources, packet-level WRR reference model.
module tb_wrr_port_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int UW = 8;
  localparam int W  = 4;
  localparam int GW = 3;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  user;
    logic        last;
    int          port;
  } beat_t;

  logic            clk = 1'b0;
  logic            axi_reset, sw_rst;
  logic [N*DW-1:0] s_tdata;
  logic [N*SW-1:0] s_tstrb;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [N*W-1:0]  weight_grp;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid, m_tlast, m_tready;
  logic [GW-1:0]   grant_port;
  logic            grant_active;

  always #5 clk = ~clk;

  wrr_port_arbiter #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .C_S_NUM_INPUT_IF     (N),
    .C_WEIGHT_WIDTH       (W)
  ) dut (
    .axi_aclk          (clk),
    .axi_reset         (axi_reset),
    .sw_rst            (sw_rst),
    .s_axis_tdata_grp  (s_tdata),
    .s_axis_tstrb_grp  (s_tstrb),
    .s_axis_tuser_grp  (s_tuser),
    .s_axis_tvalid_grp (s_tvalid),
    .s_axis_tlast_grp  (s_tlast),
    .s_axis_tready_grp (s_tready),
    .weight_grp        (weight_grp),
    .m_axis_tdata      (m_tdata),
    .m_axis_tstrb      (m_tstrb),
    .m_axis_tuser      (m_tuser),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tlast      (m_tlast),
    .m_axis_tready     (m_tready),
    .grant_port        (grant_port),
    .grant_active      (grant_active)
  );

  beat_t src_q[N][$];   // what each source still has to send
  beat_t mdl_q[N][$];   // same packets, not yet placed by the model
  beat_t exp_q[$];      // expected output beat order

  int n_vec = 0;
  int n_err = 0;
  int pkt_id = 0;
  int beat_cnt[N];
  int m_last, m_credit;
  int w_first[N], w_later[N], turns[N];
  bit mon_en = 1'b0;
  bit rdy_mode = 1'b0;  // 0: sink always ready, 1: random backpressure
  logic [N-1:0] hs = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {4'(p), 12'(pkt_id), 16'(i)};
      b.strb = 4'($urandom);
      b.user = 8'($urandom);
      b.last = (i == len - 1);
      b.port = p;
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
    pkt_id++;
  endtask

  function automatic int wsel(input int p);
    return (turns[p] == 0) ? w_first[p] : w_later[p];
  endfunction

  function automatic bit elig(input int p);
    return (mdl_q[p].size() > 0) && (wsel(p) != 0);
  endfunction

  // Reference: whole packets, at most weight per turn, circular turn order
  task automatic run_model();
    int    p;
    bit    got;
    beat_t b;
    forever begin
      got = 1'b0;
      p   = 0;
      if (m_credit != 0 && elig(m_last)) begin
        p   = m_last;
        got = 1'b1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!got && elig((m_last + k) % N)) begin
            p        = (m_last + k) % N;
            m_last   = p;
            m_credit = wsel(p);
            turns[p]++;
            got      = 1'b1;
          end
        end
      end
      if (!got) break;
      m_credit--;
      do begin
        b = mdl_q[p].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
    end
  endtask

  task automatic flush_all();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
      beat_cnt[p] = 0;
    end
    exp_q.delete();
    m_last   = N - 1;
    m_credit = 0;
  endtask

  // Called at posedge+2; leaves the bench at posedge+2 with the DUT idle
  task automatic do_reset();
    mon_en    = 1'b0;
    axi_reset = 1'b1;
    flush_all();
    repeat (2) @(posedge clk);
    #2;
    axi_reset = 1'b0;
    mon_en    = 1'b1;
  endtask

  task automatic phase_begin(input int w0, input int w1, input int w2, input int w3,
                             input int w4);
    w_first[0] = w0; w_first[1] = w1; w_first[2] = w2; w_first[3] = w3; w_first[4] = w4;
    for (int p = 0; p < N; p++) begin
      w_later[p] = w_first[p];
      turns[p]   = 0;
      weight_grp[p*W +: W] = W'(w_first[p]);
    end
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      do_reset();
    end
    // Packets on masked ports are never served; retire them
    for (int p = 0; p < N; p++) begin
      if (mdl_q[p].size() != 0) begin
        src_q[p].delete();
        mdl_q[p].delete();
      end
    end
  endtask

  task automatic phase_go(input int budget);
    run_model();
    wait_drain(budget);
  endtask

  // Source handshake capture, sampled between edges
  always @(negedge clk) hs = s_tvalid & s_tready;

  // Sources: retire accepted beats, then present the next one (valid held)
  always begin
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    end
    #2;
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0) begin
        s_tvalid[p]          = 1'b1;
        s_tlast[p]           = src_q[p][0].last;
        s_tdata[p*DW +: DW]  = src_q[p][0].data;
        s_tstrb[p*SW +: SW]  = src_q[p][0].strb;
        s_tuser[p*UW +: UW]  = src_q[p][0].user;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tlast[p]           = 1'b0;
        s_tdata[p*DW +: DW]  = '0;
        s_tstrb[p*SW +: SW]  = '0;
        s_tuser[p*UW +: UW]  = '0;
      end
    end
    m_tready = rdy_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
  end

  // Monitor: pops the scoreboard on every presented beat
  logic [DW-1:0] stall_data;
  bit            stall_pend = 1'b0;
  int            after_last = 0;
  always @(negedge clk) begin : monitor
    beat_t        e;
    logic [N-1:0] er;
    if (mon_en) begin
      if (after_last == 1) check("bubble", 64'(m_tvalid), 64'(0));
      if (after_last == 2 && !rdy_mode && exp_q.size() > 0)
        check("single_bubble", 64'(m_tvalid), 64'(1));
      if (stall_pend) check("stall_hold", {31'd0, m_tvalid, m_tdata}, {31'd0, 1'b1, stall_data});
      er = '0;
      if (m_tvalid && exp_q.size() > 0) er[exp_q[0].port] = m_tready;
      check("in_tready", 64'(s_tready), 64'(er));
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data %h port %0d expected no beat", m_tdata,
                   grant_port);
        end else begin
          e = exp_q[0];
          check("beat", 64'({m_tdata, m_tstrb, m_tuser, m_tlast, grant_port}),
                64'({e.data, e.strb, e.user, e.last, 3'(e.port)}));
          check("grant_active", 64'(grant_active), 64'(1));
          if (m_tready) begin
            void'(exp_q.pop_front());
            beat_cnt[e.port]++;
          end
        end
      end
      stall_pend = m_tvalid && !m_tready;
      stall_data = m_tdata;
      if (m_tvalid && m_tready && m_tlast) after_last = 1;
      else if (after_last == 1)            after_last = 2;
      else                                 after_last = 0;
    end else begin
      stall_pend = 1'b0;
      after_last = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, base, nw, nonzero;
    axi_reset  = 1'b1;
    sw_rst     = 1'b0;
    s_tvalid   = '0;
    s_tlast    = '0;
    s_tdata    = '0;
    s_tstrb    = '0;
    s_tuser    = '0;
    weight_grp = '0;
    m_tready   = 1'b1;
    flush_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_tready", 64'(s_tready), 64'(0));
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    check("rst_grant_active", 64'(grant_active), 64'(0));
    check("rst_grant_port", 64'(grant_port), 64'(N - 1));
    @(posedge clk);
    #2;
    axi_reset = 1'b0;
    mon_en    = 1'b1;

    // All weights 1, everyone backlogged with 2-beat packets
    phase_begin(1, 1, 1, 1, 1);
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_pkt(p, 2);
    phase_go(400);

    // Weights {3,1,0,0,0}; masked ports hold data but must never see tready
    phase_begin(3, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add_pkt(0, 2);
    for (int i = 0; i < 3; i++) add_pkt(1, 2);
    for (int p = 2; p < N; p++) add_pkt(p, 2);
    phase_go(400);

    // Lone port 3, weight 2, single-beat packets
    phase_begin(0, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) add_pkt(3, 1);
    phase_go(200);

    // Maximum weight on port 1 against weight 1 on port 0
    phase_begin(1, 15, 0, 0, 0);
    for (int i = 0; i < 17; i++) add_pkt(1, 1);
    for (int i = 0; i < 3; i++) add_pkt(0, 1);
    phase_go(400);

    // Randomised weights, counts, lengths and backpressure
    for (int it = 0; it < 6; it++) begin
      rdy_mode = it[0];
      nonzero  = 0;
      for (int p = 0; p < N; p++) begin
        w_first[p] = $urandom_range(0, 15);
        if (it >= 3 && p == it % N) w_first[p] = 15;
        if (w_first[p] != 0) nonzero = 1;
      end
      if (nonzero == 0) w_first[0] = 1;
      phase_begin(w_first[0], w_first[1], w_first[2], w_first[3], w_first[4]);
      for (int p = 0; p < N; p++) begin
        nw = $urandom_range(0, 4);
        for (int i = 0; i < nw; i++) add_pkt(p, $urandom_range(1, 4));
      end
      phase_go(3000);
    end
    rdy_mode = 1'b0;

    // Weight 4 -> 1 during port 0's second packet: this turn stays 4 packets
    do_reset();
    phase_begin(4, 1, 0, 0, 0);
    w_later[0] = 1;
    for (int i = 0; i < 7; i++) add_pkt(0, 2);
    for (int i = 0; i < 3; i++) add_pkt(1, 2);
    run_model();
    c = 0;
    while (beat_cnt[0] < 3 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("wchg_reached_pkt2", 64'(beat_cnt[0] >= 3), 64'(1));
    @(posedge clk);
    #2;
    weight_grp[0 +: W] = W'(1);
    wait_drain(400);

    // sw_rst in the middle of a 4-beat packet from port 2
    phase_begin(1, 1, 1, 1, 1);
    add_pkt(2, 4);
    run_model();
    base = beat_cnt[2];
    c    = 0;
    while (beat_cnt[2] < base + 2 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("swrst_reached_mid", 64'(beat_cnt[2] >= base + 2), 64'(1));
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    sw_rst = 1'b1;
    @(posedge clk);
    #2;
    sw_rst = 1'b0;
    flush_all();
    @(negedge clk);
    check("swrst_in_tready", 64'(s_tready), 64'(0));
    check("swrst_grant_active", 64'(grant_active), 64'(0));
    check("swrst_m_tvalid", 64'(m_tvalid), 64'(0));
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    phase_begin(1, 1, 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      add_pkt(3, $urandom_range(1, 3));
      add_pkt(1, $urandom_range(1, 3));
    end
    phase_go(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
